// File: rtl/alu32_ctrl_pkg.sv
// Shared types and constants for the gate-level ALU controller.
// Opcodes index the gate unit enables; states describe one operation's life.
package alu32_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_OPS = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_ADD  = 3'd6,
        OP_SUB  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op, input int unsigned num_ops);
        return 32'(op) < num_ops;
    endfunction

endpackage

// File: rtl/alu32_gate_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the loser whenever a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/alu32_gate_ctrl.sv
// Arbitrates two requesters onto the shared gate-level ALU, holds a one-hot
// unit enable for the settle time, then returns the captured result.
module alu32_gate_ctrl
    import alu32_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_OPS       = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Req0Valid,
    output logic                Req0Ready,
    input  logic [2:0]          Req0Op,
    input  logic [DATA_W-1:0]   Req0A,
    input  logic [DATA_W-1:0]   Req0B,
    input  logic                Req1Valid,
    output logic                Req1Ready,
    input  logic [2:0]          Req1Op,
    input  logic [DATA_W-1:0]   Req1A,
    input  logic [DATA_W-1:0]   Req1B,
    output logic [DATA_W-1:0]   GateA,
    output logic [DATA_W-1:0]   GateB,
    output logic [NUM_OPS-1:0]  GateEn,
    input  logic [DATA_W-1:0]   GateOut,
    output logic                RespValid,
    input  logic                RespReady,
    output logic                RespId,
    output logic [DATA_W-1:0]   RespData,
    output logic                RespErr
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t               state, state_nxt;
    logic [1:0]           req;
    logic [1:0]           grant;
    logic                 accept;
    logic                 cap;
    logic [2:0]           sel_op;
    logic [NUM_OPS-1:0]   sel_en;
    logic [3:0]           cnt;
    logic                 id_q;
    logic                 legal_q;

    // Requests are only visible to the arbiter in IDLE and out of reset.
    assign req = (Rst_n && state == IDLE) ? {Req1Valid, Req0Valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .req     (req),
        .advance (accept),
        .grant   (grant)
    );

    assign accept    = |grant;
    assign Req0Ready = grant[0];
    assign Req1Ready = grant[1];
    assign cap       = (state == EXEC) && (cnt == '0);
    assign sel_op    = grant[1] ? Req1Op : Req0Op;

    // An opcode with no matching unit decodes to an all-zero enable.
    always_comb begin
        sel_en = '0;
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
            sel_en[k] = (32'(sel_op) == k);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        RespValid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = EXEC;
            end
            EXEC: begin
                if (cap) state_nxt = DONE;
            end
            DONE: begin
                RespValid = 1'b1;
                if (RespReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            GateA    <= '0;
            GateB    <= '0;
            GateEn   <= '0;
            cnt      <= '0;
            id_q     <= 1'b0;
            legal_q  <= 1'b0;
            RespId   <= 1'b0;
            RespData <= '0;
            RespErr  <= 1'b0;
        end else if (accept) begin
            GateA   <= grant[1] ? Req1A : Req0A;
            GateB   <= grant[1] ? Req1B : Req0B;
            GateEn  <= sel_en;
            cnt     <= CNT_INIT;
            id_q    <= grant[1];
            legal_q <= op_is_legal(sel_op, NUM_OPS);
        end else if (cap) begin
            GateEn   <= '0;
            RespId   <= id_q;
            RespData <= legal_q ? GateOut : '0;
            RespErr  <= ~legal_q;
        end else if (state == EXEC) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_alu32_gate_ctrl.sv
// Scoreboard bench for alu32_gate_ctrl: four instances cover the default,
// a reduced unit count and both settle-time extremes.
module tb_alu32_gate_ctrl;
    import alu32_ctrl_pkg::*;

    localparam int unsigned NI = 4;
    localparam int unsigned SET  [NI] = '{2, 2, 1, 15};
    localparam int unsigned NOPS [NI] = '{8, 4, 8, 8};

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NI-1:0]        r0v, r1v, r0rdy, r1rdy, resp_valid, resp_ready, resp_id, resp_err;
    logic [NI-1:0][2:0]   r0op, r1op;
    logic [NI-1:0][31:0]  r0a, r0b, r1a, r1b, gate_a, gate_b, gate_out, resp_data;
    logic [NI-1:0][7:0]   gate_en;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned    cyc = 0;
    logic           rst_seen = 1'b0;
    logic [NI-1:0]  busy = '0;
    int unsigned    acc [NI];
    int unsigned    hs  [NI];
    logic [7:0]     exp_en [NI];
    logic [31:0]    exp_a  [NI];
    logic [31:0]    exp_b  [NI];
    exp_t           sb[$];
    logic           grant_log[$];

    function automatic logic [31:0] unit_out(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NOT:  return ~a;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_ADD:  return a + b;
            default: return a - b;
        endcase
    endfunction

    function automatic logic [31:0] gate_units(input logic [7:0] en, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (en[k]) r |= unit_out(3'(k), a, b);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            logic [NOPS[g]-1:0] en_w;
            alu32_gate_ctrl #(
                .SETTLE_CYCLES (SET[g]),
                .NUM_OPS       (NOPS[g])
            ) dut (
                .Clk       (clk),
                .Rst_n     (rst_n),
                .Req0Valid (r0v[g]),
                .Req0Ready (r0rdy[g]),
                .Req0Op    (r0op[g]),
                .Req0A     (r0a[g]),
                .Req0B     (r0b[g]),
                .Req1Valid (r1v[g]),
                .Req1Ready (r1rdy[g]),
                .Req1Op    (r1op[g]),
                .Req1A     (r1a[g]),
                .Req1B     (r1b[g]),
                .GateA     (gate_a[g]),
                .GateB     (gate_b[g]),
                .GateEn    (en_w),
                .GateOut   (gate_out[g]),
                .RespValid (resp_valid[g]),
                .RespReady (resp_ready[g]),
                .RespId    (resp_id[g]),
                .RespData  (resp_data[g]),
                .RespErr   (resp_err[g])
            );
            assign gate_en[g]  = 8'(en_w);
            assign gate_out[g] = gate_units(gate_en[g], gate_a[g], gate_b[g]);
        end
    endgenerate

    always @(posedge clk) begin
        cyc++;
        rst_seen = !rst_n;
    end

    // Monitor: per-cycle timing expectations plus scoreboard push/pop.
    logic        m_in_exec, m_exp_rv, m_rq, m_legal;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b;
    exp_t        m_e;

    always @(negedge clk) begin
        if (rst_seen) begin
            busy = '0;
            sb.delete();
        end
        for (int g = 0; g < NI; g++) begin
            check("rdy_excl", 32'(r0rdy[g] & r1rdy[g]), 32'd0);
            check("rdy_busy", 32'(busy[g] & (r0rdy[g] | r1rdy[g])), 32'd0);
            m_in_exec = busy[g] && (cyc > acc[g]) && (cyc <= acc[g] + SET[g]);
            check("gate_en", 32'(gate_en[g]), m_in_exec ? 32'(exp_en[g]) : 32'd0);
            if (m_in_exec) begin
                check("gate_a", gate_a[g], exp_a[g]);
                check("gate_b", gate_b[g], exp_b[g]);
            end
            m_exp_rv = busy[g] && (cyc > acc[g] + SET[g]);
            check("resp_valid", 32'(resp_valid[g]), 32'(m_exp_rv));
            if (resp_valid[g]) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(resp_valid[g]), 32'd0);
                end else begin
                    check("resp_data", resp_data[g], sb[0].data);
                    check("resp_id", 32'(resp_id[g]), 32'(sb[0].id));
                    check("resp_err", 32'(resp_err[g]), 32'(sb[0].err));
                    if (resp_ready[g]) begin
                        void'(sb.pop_front());
                        busy[g] = 1'b0;
                        hs[g]   = cyc;
                    end
                end
            end
            if (!busy[g] && (r0rdy[g] || r1rdy[g])) begin
                m_rq      = r1rdy[g];
                m_op      = m_rq ? r1op[g] : r0op[g];
                m_a       = m_rq ? r1a[g] : r0a[g];
                m_b       = m_rq ? r1b[g] : r0b[g];
                m_legal   = 32'(m_op) < NOPS[g];
                exp_en[g] = m_legal ? (8'b1 << m_op) : 8'd0;
                exp_a[g]  = m_a;
                exp_b[g]  = m_b;
                m_e.id    = m_rq;
                m_e.data  = m_legal ? unit_out(m_op, m_a, m_b) : 32'd0;
                m_e.err   = !m_legal;
                sb.push_back(m_e);
                grant_log.push_back(m_rq);
                busy[g] = 1'b1;
                acc[g]  = cyc;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        for (int g = 0; g < NI; g++) begin
            check({tag, "_ready"}, 32'(r0rdy[g] | r1rdy[g]), 32'd0);
            check({tag, "_gate_en"}, 32'(gate_en[g]), 32'd0);
            check({tag, "_gate_a"}, gate_a[g], 32'd0);
            check({tag, "_gate_b"}, gate_b[g], 32'd0);
            check({tag, "_valid"}, 32'(resp_valid[g]), 32'd0);
            check({tag, "_id"}, 32'(resp_id[g]), 32'd0);
            check({tag, "_data"}, resp_data[g], 32'd0);
            check({tag, "_err"}, 32'(resp_err[g]), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input int g, input int rq, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (rq == 0) begin
            r0op[g] = op; r0a[g] = a; r0b[g] = b; r0v[g] = 1'b1;
        end else begin
            r1op[g] = op; r1a[g] = a; r1b[g] = b; r1v[g] = 1'b1;
        end
        for (int i = 0; i < 40 && !busy[g]; i++) begin
            @(posedge clk); #1;
        end
        if (rq == 0) r0v[g] = 1'b0;
        else         r1v[g] = 1'b0;
        if (!busy[g]) check("accept_timeout", 32'(busy[g]), 32'd1);
    endtask

    task automatic wait_done(input int g);
        for (int i = 0; i < 60 && busy[g]; i++) begin
            @(posedge clk); #1;
        end
        if (busy[g]) check("done_timeout", 32'(busy[g]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned hs_before;
        rst_n      = 1'b0;
        r0v        = '0;
        r1v        = '0;
        resp_ready = '1;
        r0op = '0; r1op = '0;
        r0a  = '0; r0b  = '0; r1a = '0; r1b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs_zero("reset");

        issue(0, 0, OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_done(0);

        // Contention from a fresh reset so the pointer starts at requester 0.
        do_reset();
        grant_log.delete();
        r0op[0] = OP_XOR; r0a[0] = 32'h12345678; r0b[0] = 32'h0F0F00FF;
        r1op[0] = OP_SUB; r1a[0] = 32'h00000010; r1b[0] = 32'h00000020;
        r0v[0] = 1'b1; r1v[0] = 1'b1;
        for (int i = 0; i < 200 && grant_log.size() < 4; i++) begin
            @(posedge clk); #1;
        end
        r0v[0] = 1'b0; r1v[0] = 1'b0;
        check("cont_grants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("cont_order", 32'(grant_log[i]), 32'(i % 2));
        end
        wait_done(0);

        resp_ready[0] = 1'b0;
        issue(0, 0, OP_OR, 32'hA0A0A0A0, 32'h0000FFFF);
        hs_before = hs[0];
        r1op[0] = OP_NAND; r1a[0] = 32'hFFFFFFFF; r1b[0] = 32'h0000F0F0; r1v[0] = 1'b1;
        for (int i = 0; i < 50 && !resp_valid[0]; i++) begin
            @(posedge clk); #1;
        end
        check("bp_valid", 32'(resp_valid[0]), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        resp_ready[0] = 1'b1;
        for (int i = 0; i < 20 && !(busy[0] && hs[0] != hs_before); i++) begin
            @(posedge clk); #1;
        end
        check("bp_regrant", acc[0], hs[0] + 1);
        r1v[0] = 1'b0;
        wait_done(0);

        issue(1, 1, 3'd6, 32'h11111111, 32'h22222222);
        wait_done(1);

        // Requester 0 alone leaves the pointer at 1; reset must restore 0.
        issue(0, 0, OP_ADD, 32'h7FFFFFFF, 32'h00000001);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_outputs_zero("rst_mid");
        repeat (SET[0] + 4) @(posedge clk);
        #1;
        check("rst_no_resp", 32'(resp_valid[0]), 32'd0);
        grant_log.delete();
        r0op[0] = OP_NOR; r0a[0] = 32'h0000FFFF; r0b[0] = 32'h00FF00FF;
        r1op[0] = OP_AND; r1a[0] = 32'hFFFFFFFF; r1b[0] = 32'h12345678;
        r0v[0] = 1'b1; r1v[0] = 1'b1;
        for (int i = 0; i < 20 && grant_log.size() == 0; i++) begin
            @(posedge clk); #1;
        end
        r0v[0] = 1'b0; r1v[0] = 1'b0;
        check("rst_grants", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) check("rst_first_grant", 32'(grant_log[0]), 32'd0);
        wait_done(0);

        issue(2, 0, OP_NOT, 32'h00000000, 32'h5A5A5A5A);
        wait_done(2);
        issue(3, 1, OP_NOT, 32'h00000000, 32'hA5A5A5A5);
        wait_done(3);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu32_gate_ctrl.md
Name: alu32_gate_ctrl

Overview:
- Controller and arbiter for the 32-bit gate-level ALU (G_And32, G_Or32, G_Not32, G_Add32, etc.).
- Each gate unit has an active-high Enable, and the unit outputs are ORed externally onto GateOut.
- Two requesters share the ALU. Round-robin arbitration selects one, and the block drives its operands with exactly one one-hot unit enable.
- The block waits a programmable settle time for gate ripple, captures the result, and returns it with a requester ID.

Parameters:
- SETTLE_CYCLES, 2: cycles GateEn is held before capture; legal range 1..15.
- NUM_OPS, 8: number of gate units (GateEn width); legal range 1..8.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst_n  in  1  synchronous reset, active-low.
- Req0Valid  in  1  requester 0 has an operation pending.
- Req0Ready  out  1  requester 0 operation accepted this cycle.
- Req0Op  in  3  requester 0 opcode.
- Req0A, Req0B  in  32 each  requester 0 operands.
- Req1Valid, Req1Ready, Req1Op, Req1A, Req1B  same widths and meaning, for requester 1.
- GateA, GateB  out  32 each  operands to all gate units.
- GateEn  out  NUM_OPS  one-hot unit enable; bit k enables the opcode k unit.
- GateOut  in  32  OR-combined unit outputs.
- RespValid  out  1  result available.
- RespReady  in  1  consumer takes the result.
- RespId  out  1  ID of the requester that issued the operation.
- RespData  out  32  captured result.
- RespErr  out  1  opcode was illegal (>= NUM_OPS).

Behaviour:
- Reset (Rst_n=0 at a clock edge):
  - State goes to IDLE and the RR pointer goes to 0.
  - All outputs go to 0: Req*Ready, GateEn, GateA, GateB, RespValid, RespId, RespData, RespErr.
  - Reset mid-operation discards the operation in flight. No response is produced for it.
- IDLE:
  - Grant goes to the valid requester. If both are valid, grant goes to the one the pointer selects.
  - ReqNReady is asserted combinationally for the granted requester only, in that cycle.
  - On that edge the block latches Op/A/B and Id, and the pointer moves to the non-granted requester.
  - Next state is EXEC, with cnt=SETTLE_CYCLES-1.
- EXEC:
  - GateA and GateB hold the latched operands.
  - GateEn = 1<<Op, stable for all SETTLE_CYCLES cycles.
  - cnt decrements each cycle.
  - At cnt==0 the block captures GateOut into RespData, clears GateEn on the next edge, and enters DONE.
- Illegal opcode (Op>=NUM_OPS):
  - GateEn stays all-zero throughout EXEC.
  - Timing is identical to a legal op.
  - RespData=0 and RespErr=1.
- DONE:
  - RespValid=1, with RespId, RespData and RespErr held stable.
  - RespValid&RespReady moves the block to IDLE and clears RespValid.
  - No new grant is given in the same cycle. The earliest next grant is the following cycle.
- GateA and GateB keep their last value outside EXEC; only GateEn is qualified.
- Latency: accept at cycle T.
  - GateEn is high in T+1..T+SETTLE_CYCLES.
  - RespValid rises at T+SETTLE_CYCLES+1.
  - Peak throughput is one op per SETTLE_CYCLES+2 cycles.
- Invariants:
  - Req0Ready and Req1Ready are never high together.
  - popcount(GateEn) is at most 1.
  - RespValid and GateEn are never high together.
  - Requests are not accepted while in EXEC or DONE.
- A requester that deasserts Valid before it is granted is simply not granted. The pointer is unchanged.

Decomposition:
- Package alu32_ctrl_pkg holds:
  - Opcode constants: OP_AND=0, OP_OR=1, OP_NOT=2, OP_XOR=3, OP_NAND=4, OP_NOR=5, OP_ADD=6, OP_SUB=7.
  - State encoding: IDLE, EXEC, DONE.
  - Operand width constant 32.
- Sub-module rr_arb2 is a two-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: grant[1:0].
  - Holds the pointer register and resets it to 0.

Test Plan:
- Single op: Req0 OP_AND, A=32'hFFFF0000, B=32'h0F0F0F0F, SETTLE_CYCLES=2, RespReady=1.
  - Required: GateEn=8'h01 for exactly 2 cycles.
  - Required: RespValid at accept+3, RespData=32'h0F0F0000, RespId=0, RespErr=0.
- Contention: both valid every cycle, each with distinct ops.
  - Required: grants alternate 0,1,0,1 starting with 0 after reset.
  - Required: Req0Ready and Req1Ready are never high together.
  - Required: RespId sequence is 0,1,0,1.
- Backpressure: RespReady=0 for 5 cycles after RespValid.
  - Required: RespValid and RespData hold stable and GateEn stays 0.
  - Required: no ReqReady is asserted until the cycle after RespReady=1.
- Illegal opcode: NUM_OPS=4, Req1Op=6.
  - Required: GateEn stays 0 throughout.
  - Required: response at accept+SETTLE_CYCLES+1 with RespData=0, RespErr=1, RespId=1.
- Reset mid-EXEC: assert Rst_n=0 for one edge during the second EXEC cycle.
  - Required: all outputs are 0 on the next cycle and no RespValid follows.
  - Required: with both requesters valid afterwards, the first grant goes to requester 0.
- Settle sweep: SETTLE_CYCLES=1 and 15 with OP_NOT, A=32'h00000000.
  - Required: GateEn is high for exactly 1 / 15 cycles.
  - Required: RespData=32'hFFFFFFFF captured at the final EXEC cycle.
